// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcode, ALU select and sequencer state definitions
//
// Purpose: constants shared by the control sequencer, ALU and register file.
//   - 8-bit opcode values of the instruction word
//   - 3-bit ALUOP select codes
//   - sequencer FSM state encoding
//   - cnt_width(): wait-counter width for a pair of wait parameters
package cpu_defs_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } seq_state_t;

  // Counter must hold the larger wait value without wrapping.
  function automatic int cnt_width(input int add_wait, input int logic_wait);
    int m;
    m = (add_wait > logic_wait) ? add_wait : logic_wait;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational decode of the latched instruction word
//
// Purpose: turns the instruction register into ALU controls, register
// addresses and the EXEC wait length.
// Ports:
//   ir           in   32      latched instruction
//   alu_op       out  3       ALU select
//   imm_sel      out  1       DATA2 from immediate
//   neg_sel      out  1       DATA2 negated (sub)
//   wait_cycles  out  CNT_W   EXEC length for this opcode
//   legal        out  1       opcode is defined
//   read1/read2  out  REG_AW  register-file read addresses
//   dest         out  REG_AW  write address
//   imm          out  8       immediate byte
module instr_field_decode
  import cpu_defs_pkg::*;
#(
  parameter int ADD_WAIT   = 2,
  parameter int LOGIC_WAIT = 1,
  parameter int REG_AW     = 3,
  parameter int CNT_W      = 2
) (
  input  logic [31:0]       ir,
  output logic [2:0]        alu_op,
  output logic              imm_sel,
  output logic              neg_sel,
  output logic [CNT_W-1:0]  wait_cycles,
  output logic              legal,
  output logic [REG_AW-1:0] read1,
  output logic [REG_AW-1:0] read2,
  output logic [REG_AW-1:0] dest,
  output logic [7:0]        imm
);

  // Upper bits of the dest/src1 fields carry no meaning.
  logic unused_field_bits;
  assign unused_field_bits = ^{ir[23:16+REG_AW], ir[15:8+REG_AW]};

  assign dest = ir[16 +: REG_AW];
  assign imm  = ir[7:0];

  always_comb begin
    alu_op  = ALU_FWD;
    imm_sel = 1'b0;
    neg_sel = 1'b0;
    legal   = 1'b1;
    read1   = ir[8 +: REG_AW];
    read2   = ir[0 +: REG_AW];
    case (ir[31:24])
      OP_LOADI: begin
        imm_sel = 1'b1;
        read1   = '0;
        read2   = '0;
      end
      OP_MOV:  alu_op = ALU_FWD;
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB: begin
        alu_op  = ALU_ADD;
        neg_sel = 1'b1;
      end
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      default: begin
        legal = 1'b0;
        read1 = '0;
        read2 = '0;
      end
    endcase
    wait_cycles = (alu_op == ALU_ADD) ? CNT_W'(ADD_WAIT) : CNT_W'(LOGIC_WAIT);
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// rtl/cpu_control_sequencer.sv - multi-cycle control unit for the 8-bit ALU datapath
//
// Purpose: accepts instructions from fetch, decodes them, holds ALU controls
// for the opcode's settle time and issues a one-cycle register write.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   instruction, instr_valid      instruction from fetch
//   instr_ready                   high only in IDLE
//   readreg1, readreg2, writereg  register-file addresses
//   writeenable                   one-cycle write strobe
//   aluop, immediate, imm_sel, neg_sel   ALU controls
//   illegal                       one-cycle pulse on undefined opcode
//   busy                          high outside IDLE
module cpu_control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int ADD_WAIT   = 2,
  parameter int LOGIC_WAIT = 1,
  parameter int REG_AW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [REG_AW-1:0] readreg1,
  output logic [REG_AW-1:0] readreg2,
  output logic [REG_AW-1:0] writereg,
  output logic              writeenable,
  output logic [2:0]        aluop,
  output logic [7:0]        immediate,
  output logic              imm_sel,
  output logic              neg_sel,
  output logic              illegal,
  output logic              busy
);

  localparam int CNT_W = cnt_width(ADD_WAIT, LOGIC_WAIT);

  seq_state_t        state;
  logic [31:0]       ir;
  logic [CNT_W-1:0]  cnt;

  logic [2:0]        d_alu_op;
  logic              d_imm_sel;
  logic              d_neg_sel;
  logic [CNT_W-1:0]  d_wait;
  logic              d_legal;
  logic [REG_AW-1:0] d_read1;
  logic [REG_AW-1:0] d_read2;
  logic [REG_AW-1:0] d_dest;
  logic [7:0]        d_imm;

  instr_field_decode #(
    .ADD_WAIT   (ADD_WAIT),
    .LOGIC_WAIT (LOGIC_WAIT),
    .REG_AW     (REG_AW),
    .CNT_W      (CNT_W)
  ) u_decode (
    .ir          (ir),
    .alu_op      (d_alu_op),
    .imm_sel     (d_imm_sel),
    .neg_sel     (d_neg_sel),
    .wait_cycles (d_wait),
    .legal       (d_legal),
    .read1       (d_read1),
    .read2       (d_read2),
    .dest        (d_dest),
    .imm         (d_imm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ir          <= '0;
      cnt         <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      readreg1    <= '0;
      readreg2    <= '0;
      writereg    <= '0;
      writeenable <= 1'b0;
      aluop       <= ALU_FWD;
      immediate   <= '0;
      imm_sel     <= 1'b0;
      neg_sel     <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          illegal     <= 1'b0;
          writeenable <= 1'b0;
          if (instr_valid && instr_ready) begin
            ir          <= instruction;
            state       <= ST_DECODE;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (d_legal) begin
            aluop     <= d_alu_op;
            imm_sel   <= d_imm_sel;
            neg_sel   <= d_neg_sel;
            immediate <= d_imm;
            readreg1  <= d_read1;
            readreg2  <= d_read2;
            writereg  <= d_dest;
            cnt       <= d_wait;
            state     <= ST_EXEC;
          end else begin
            // Undefined opcode: drop controls to 0 and return straight to IDLE.
            aluop       <= ALU_FWD;
            imm_sel     <= 1'b0;
            neg_sel     <= 1'b0;
            immediate   <= '0;
            readreg1    <= '0;
            readreg2    <= '0;
            writereg    <= '0;
            illegal     <= 1'b1;
            state       <= ST_IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        ST_EXEC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state       <= ST_WB;
            writeenable <= 1'b1;
          end
        end
        ST_WB: begin
          writeenable <= 1'b0;
          state       <= ST_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb/tb_cpu_control_sequencer.sv - directed self-checking bench for cpu_control_sequencer
module tb_cpu_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  readreg1;
  logic [2:0]  readreg2;
  logic [2:0]  writereg;
  logic        writeenable;
  logic [2:0]  aluop;
  logic [7:0]  immediate;
  logic        imm_sel;
  logic        neg_sel;
  logic        illegal;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_control_sequencer #(
    .ADD_WAIT   (2),
    .LOGIC_WAIT (1),
    .REG_AW     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .readreg1    (readreg1),
    .readreg2    (readreg2),
    .writereg    (writereg),
    .writeenable (writeenable),
    .aluop       (aluop),
    .immediate   (immediate),
    .imm_sel     (imm_sel),
    .neg_sel     (neg_sel),
    .illegal     (illegal),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    instruction = '0;
    instr_valid = 1'b0;

    // 1. reset
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_we", writeenable, 0);
    check("rst_aluop", aluop, 0);
    check("rst_illegal", illegal, 0);
    check("rst_imm", immediate, 0);

    // 2. loadi r4 <- 0x2A (W=1): DECODE 1, EXEC 2, WB 3, IDLE 4
    instruction = 32'h00_04_00_2A;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("ldi_c1_busy", busy, 1);
    check("ldi_c1_ready", instr_ready, 0);
    check("ldi_c1_we", writeenable, 0);
    tick();
    check("ldi_c2_we", writeenable, 0);
    check("ldi_c2_imm_sel", imm_sel, 1);
    check("ldi_c2_imm", immediate, 8'h2A);
    check("ldi_c2_aluop", aluop, 0);
    check("ldi_c2_rr1", readreg1, 0);
    check("ldi_c2_rr2", readreg2, 0);
    tick();
    check("ldi_c3_we", writeenable, 1);
    check("ldi_c3_wreg", writereg, 4);
    check("ldi_c3_imm_sel", imm_sel, 1);
    tick();
    check("ldi_c4_we", writeenable, 0);
    check("ldi_c4_ready", instr_ready, 1);
    check("ldi_c4_busy", busy, 0);
    check("ldi_c4_imm_hold", immediate, 8'h2A);

    // 3. sub r1 <- r2 - r3 (W=2): WB in cycle 4; instruction bus changes are ignored
    instruction = 32'h03_01_02_03;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instruction = 32'h05_07_07_07;
    check("sub_c1_we", writeenable, 0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check($sformatf("sub_c%0d_aluop", c), aluop, 1);
      check($sformatf("sub_c%0d_neg", c), neg_sel, 1);
      check($sformatf("sub_c%0d_imm_sel", c), imm_sel, 0);
      check($sformatf("sub_c%0d_rr1", c), readreg1, 2);
      check($sformatf("sub_c%0d_rr2", c), readreg2, 3);
      check($sformatf("sub_c%0d_we", c), writeenable, (c == 4) ? 1 : 0);
      check($sformatf("sub_c%0d_ready", c), instr_ready, 0);
    end
    check("sub_c4_wreg", writereg, 1);
    tick();
    check("sub_c5_ready", instr_ready, 1);
    check("sub_c5_we", writeenable, 0);

    // 4. illegal opcode 0x07
    instruction = 32'h07_05_06_07;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("ill_c1_illegal", illegal, 0);
    check("ill_c1_we", writeenable, 0);
    tick();
    check("ill_c2_illegal", illegal, 1);
    check("ill_c2_ready", instr_ready, 1);
    check("ill_c2_busy", busy, 0);
    check("ill_c2_we", writeenable, 0);
    check("ill_c2_aluop", aluop, 0);
    check("ill_c2_neg", neg_sel, 0);
    check("ill_c2_wreg", writereg, 0);
    tick();
    check("ill_c3_illegal", illegal, 0);
    check("ill_c3_we", writeenable, 0);

    // 5. back-to-back and (dest 0x0D -> r5) then or, valid held high
    instruction = 32'h04_0D_01_02;
    instr_valid = 1'b1;
    tick();
    instruction = 32'h05_03_04_06;
    check("and_c1_ready", instr_ready, 0);
    tick();
    check("and_c2_aluop", aluop, 3'b010);
    check("and_c2_we", writeenable, 0);
    tick();
    check("and_c3_we", writeenable, 1);
    check("and_c3_wreg", writereg, 5);
    tick();
    check("b2b_c4_ready", instr_ready, 1);
    check("b2b_c4_we", writeenable, 0);
    tick();
    instr_valid = 1'b0;
    check("or_c1_busy", busy, 1);
    check("or_c1_we", writeenable, 0);
    tick();
    check("or_c2_aluop", aluop, 3'b011);
    check("or_c2_rr1", readreg1, 4);
    check("or_c2_rr2", readreg2, 6);
    check("or_c2_we", writeenable, 0);
    tick();
    check("or_c3_we", writeenable, 1);
    check("or_c3_wreg", writereg, 3);
    tick();
    check("or_c4_we", writeenable, 0);
    check("or_c4_ready", instr_ready, 1);

    // 6. reset during EXEC of add
    instruction = 32'h02_02_03_04;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("add_c2_aluop", aluop, 1);
    check("add_c2_neg", neg_sel, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", instr_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_aluop", aluop, 0);
    check("abort_rr1", readreg1, 0);
    check("abort_wreg", writereg, 0);
    check("abort_we", writeenable, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("abort_we_after%0d", c), writeenable, 0);
      check($sformatf("abort_busy_after%0d", c), busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
